// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: drives program-memory reads from an internal PC,
// buffers fetched words in a small prefetch FIFO and hands one instruction
// per controller request to instruction_register with a one-cycle LoadIR.
// A pc_load redirects the stream, flushes the FIFO and drops any read in flight.
// Optional feature macro: IFU_HALT_DETECT_EN (stop prefetch at opcode 4'hF, adds 'halted').
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   fetch_next,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_load_value,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   LoadIR,
  output logic                   fetch_stall
`ifdef IFU_HALT_DETECT_EN
  ,
  output logic                   halted
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic                   pending;
  logic                   stop;

  logic serve;
  logic ack_take;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;

`ifdef IFU_HALT_DETECT_EN
  localparam logic [3:0] HALT_OP = 4'hF;
`else
  assign stop = 1'b0;
`endif

  // Delivery / push decisions for the current cycle.
  always_comb begin
    serve       = pending | fetch_next;
    ack_take    = (state == REQ) && mem_ack;
    fifo_empty  = (count == '0);
    pop         = serve && !fifo_empty;
    // A waiting request with an empty FIFO takes the returning word directly.
    bypass      = serve && fifo_empty && ack_take;
    push        = ack_take && !bypass;
    fetch_stall = pending && fifo_empty;
  end

  // Fetch FSM, prefetch FIFO and delivery registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_ADDR;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_ADDR;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      LoadIR      <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
`ifdef IFU_HALT_DETECT_EN
      halted      <= 1'b0;
      stop        <= 1'b0;
`endif
    end else if (pc_load) begin
      pc      <= pc_load_value;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      LoadIR  <= 1'b0;
      pending <= serve;
      // A read still outstanding must be absorbed before the new stream starts.
      if (state != IDLE && !mem_ack) begin
        state <= DROP;
      end else begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
`ifdef IFU_HALT_DETECT_EN
      halted <= 1'b0;
      stop   <= 1'b0;
`endif
    end else begin
      LoadIR <= 1'b0;
      if (pop) begin
        instruction <= fifo_instr[rd_ptr];
        instr_pc    <= fifo_pc[rd_ptr];
        LoadIR      <= 1'b1;
        pending     <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
`ifdef IFU_HALT_DETECT_EN
        if (fifo_instr[rd_ptr][INSTR_WIDTH-1 -: 4] == HALT_OP) halted <= 1'b1;
`endif
      end else if (bypass) begin
        instruction <= mem_rdata;
        instr_pc    <= pc;
        LoadIR      <= 1'b1;
        pending     <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
        if (mem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OP) halted <= 1'b1;
`endif
      end else begin
        pending <= serve;
      end

      if (push) begin
        fifo_instr[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]    <= pc;
        wr_ptr             <= wr_ptr + PW'(1);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end

      unique case (state)
        IDLE: begin
          if (count < DEPTH_C && !stop) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            pc      <= pc + ADDR_WIDTH'(1);
            state   <= IDLE;
            mem_req <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
            if (mem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OP) stop <= 1'b1;
`endif
          end
        end
        DROP: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a behavioural program memory with a
// programmable ack delay answers requests; expected {pc, instruction} pairs
// are queued per fetch_next and matched against each LoadIR strobe.
module tb_instruction_fetch_unit;
  localparam int unsigned AW   = 8;
  localparam int unsigned IW   = 8;
  localparam int unsigned HOLD = 100000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          fetch_next = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_value = '0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instr_pc;
  logic          LoadIR;
  logic          fetch_stall;
`ifdef IFU_HALT_DETECT_EN
  logic          halted;
`endif

  int checks = 0;
  int errors = 0;

  logic [IW-1:0]    mem [256];
  logic [AW+IW-1:0] exp_q [$];
  logic [AW-1:0]    req_log [$];
  logic [AW-1:0]    exp_pc = '0;
  int unsigned      ack_delay = 0;
  int unsigned      wait_cnt = 0;

  instruction_fetch_unit #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(2), .RESET_PC(0)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fetch_next(fetch_next), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .instruction(instruction), .instr_pc(instr_pc), .LoadIR(LoadIR),
    .fetch_stall(fetch_stall)
`ifdef IFU_HALT_DETECT_EN
    , .halted(halted)
`endif
  );

  always #5 clock = ~clock;

  // Program image: opcode (addr+1)%15 never reaches 4'hF, data = addr[3:0].
  function automatic logic [IW-1:0] image(input int unsigned a);
    logic [3:0] op;
    logic [3:0] dat;
    op  = 4'((a + 1) % 15);
    dat = 4'(a);
    return {op, dat};
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, logs served addresses.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = image(i);
    forever begin
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
      if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          req_log.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard consumer: every LoadIR must match the oldest expectation.
  initial begin
    logic [AW+IW-1:0] e;
    forever begin
      @(negedge clock); #1;
      if (LoadIR === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_loadir: got pc=%h instr=%h, required no strobe", instr_pc, instruction);
        end else begin
          e = exp_q.pop_front();
          if ({instr_pc, instruction} !== e) begin
            errors++;
            $display("FAIL delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                     instr_pc, instruction, e[AW+IW-1:IW], e[IW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic do_reset(input int unsigned delay);
    ack_delay = delay;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
    req_log.delete();
    exp_pc = '0;
  endtask

  task automatic expect_next();
    exp_q.push_back({exp_pc, mem[exp_pc]});
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic pulse_fetch();
    fetch_next = 1'b1;
    tick();
    fetch_next = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d undelivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40 && mem_req !== 1'b1; i++) tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_timeout: got mem_req=%b, required 1", name, mem_req);
    end
  endtask

  task automatic do_fetch(input bit now);
    expect_next();
    pulse_fetch();
    if (now) begin
      checks++;
      if (LoadIR !== 1'b1) begin
        errors++;
        $display("FAIL fetch_latency: got LoadIR=%b, required 1", LoadIR);
      end
    end
    wait_drain("fetch");
    tick();
    checks++;
    if (LoadIR !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width: got LoadIR=%b, required 0", LoadIR);
    end
  endtask

  // Fills the FIFO, then holds memory, delivers n entries and leaves a read outstanding.
  task automatic setup_held(input int n);
    do_reset(0);
    for (int i = 0; i < 40 && req_log.size() < 2; i++) tick();
    tick(); tick();
    ack_delay = HOLD;
    for (int i = 0; i < n; i++) do_fetch(1);
    wait_req("setup");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks += 6;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h, required 00", mem_addr); end
    if (LoadIR !== 1'b0) begin errors++; $display("FAIL rst_loadir: got %b, required 0", LoadIR); end
    if (instruction !== 8'h00) begin errors++; $display("FAIL rst_instruction: got %h, required 00", instruction); end
    if (instr_pc !== 8'h00) begin errors++; $display("FAIL rst_instr_pc: got %h, required 00", instr_pc); end
    if (fetch_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b, required 0", fetch_stall); end
  endtask

  task automatic test_basic();
    do_reset(0);
    for (int i = 0; i < 3; i++) do_fetch(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instruction !== 8'h32 || instr_pc !== 8'h02 || LoadIR !== 1'b0) begin
        errors++;
        $display("FAIL hold_outputs: got instr=%h pc=%h LoadIR=%b, required 32 02 0", instruction, instr_pc, LoadIR);
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset(0);
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL full_no_req: got mem_req=%b, required 0", mem_req);
      end
    end
    checks++;
    if (req_log.size() != 2) begin
      errors++;
      $display("FAIL full_req_count: got %0d, required 2", req_log.size());
    end
    do_fetch(1);
    for (int i = 0; i < 20 && req_log.size() < 3; i++) tick();
    checks++;
    if (req_log.size() < 3 || req_log[2] !== 8'h02) begin
      errors++;
      $display("FAIL full_next_addr: got log size %0d, required addr 02 as third request", req_log.size());
    end
  endtask

  task automatic test_stall();
    int stall_cnt;
    logic prev_ack;
    bit seen;
    stall_cnt = 0;
    prev_ack = 1'b0;
    seen = 1'b0;
    do_reset(5);
    expect_next();
    pulse_fetch();
    for (int i = 0; i < 30 && !seen; i++) begin
      if (LoadIR === 1'b1) begin
        seen = 1'b1;
        checks += 2;
        if (prev_ack !== 1'b1) begin errors++; $display("FAIL stall_ack_to_loadir: got prev mem_ack=%b, required 1", prev_ack); end
        if (fetch_stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b, required 0", fetch_stall); end
      end else begin
        if (fetch_stall === 1'b1) stall_cnt++;
        prev_ack = mem_ack;
        tick();
      end
    end
    checks++;
    if (stall_cnt != 6) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, required 6", stall_cnt);
    end
    wait_drain("stall");
  endtask

  task automatic test_jump();
    int idx;
    setup_held(1);
    checks++;
    if (mem_addr !== 8'h02) begin errors++; $display("FAIL jump_pre_addr: got %h, required 02", mem_addr); end
    pc_load = 1'b1;
    pc_load_value = 8'h40;
    tick();
    pc_load = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin
      errors++;
      $display("FAIL jump_drop_hold: got req=%b addr=%h, required 1 02", mem_req, mem_addr);
    end
    exp_pc = 8'h40;
    expect_next();
    pulse_fetch();
    tick(); tick();
    checks++;
    if (fetch_stall !== 1'b1) begin errors++; $display("FAIL jump_stall: got %b, required 1", fetch_stall); end
    idx = req_log.size();
    ack_delay = 0;
    wait_drain("jump");
    checks++;
    if (req_log.size() < idx + 2 || req_log[idx] !== 8'h02 || req_log[idx+1] !== 8'h40) begin
      errors++;
      $display("FAIL jump_req_order: got log size %0d, required stale 02 then 40", req_log.size());
    end
  endtask

  task automatic test_ignore_second();
    do_reset(HOLD);
    expect_next();
    pulse_fetch();
    pulse_fetch();
    tick();
    ack_delay = 0;
    wait_drain("ignore");
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (LoadIR !== 1'b0) begin errors++; $display("FAIL ignore_extra_strobe: got LoadIR=%b, required 0", LoadIR); end
    end
  endtask

  task automatic test_wrap();
    do_reset(0);
    tick(); tick(); tick();
    pc_load = 1'b1;
    pc_load_value = 8'hFF;
    tick();
    pc_load = 1'b0;
    exp_pc = 8'hFF;
    do_fetch(0);
    do_fetch(0);
  endtask

  task automatic test_reset_mid_req();
    setup_held(2);
    reset = 1'b1;
    tick();
    checks += 5;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b, required 0", mem_req); end
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h, required 00", mem_addr); end
    if (instruction !== 8'h00) begin errors++; $display("FAIL midrst_instr: got %h, required 00", instruction); end
    if (instr_pc !== 8'h00) begin errors++; $display("FAIL midrst_pc: got %h, required 00", instr_pc); end
    if (LoadIR !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got %b %b, required 0 0", LoadIR, fetch_stall); end
    reset = 1'b0;
    exp_q.delete();
    req_log.delete();
    ack_delay = 0;
  endtask

  task automatic test_halt_opcode();
    bit found6;
    do_reset(0);
    mem[5] = 8'hF0;
    for (int i = 0; i < 5; i++) do_fetch(0);
`ifdef IFU_HALT_DETECT_EN
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b, required 0", halted); end
`endif
    do_fetch(0);
`ifdef IFU_HALT_DETECT_EN
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b, required 1", halted); end
`endif
    for (int i = 0; i < 20; i++) tick();
    found6 = 1'b0;
    foreach (req_log[i]) if (req_log[i] === 8'h06) found6 = 1'b1;
    checks++;
`ifdef IFU_HALT_DETECT_EN
    if (found6) begin errors++; $display("FAIL halt_stop: got request to 06, required none"); end
    pc_load = 1'b1;
    pc_load_value = 8'h10;
    tick();
    pc_load = 1'b0;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b, required 0", halted); end
`else
    if (!found6) begin errors++; $display("FAIL opcode_f_ordinary: got no request to 06, required one"); end
`endif
    mem[5] = image(5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_stall();
    test_jump();
    test_ignore_second();
    test_wrap();
    test_reset_mid_req();
    test_halt_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
